// File: rtl/mem_bus_dma_if.sv
// Native memory bus: one master request channel, one responder completion.
// Master drives valid/wstrb/addr/wdata; responder returns ready/rdata.
interface mem_bus_dma_if #(
  parameter int ADDR_W = 10
);
  logic              mem_valid;
  logic              mem_ready;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_valid,
    output mem_wstrb,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_wstrb,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_dma.sv
// Word-copy DMA master on the native memory bus (read, gap, write, gap).
// Define MEM_DMA_TIMEOUT_EN to abort a stalled RD/WR after TIMEOUT_CYCLES.
module mem_bus_dma #(
  parameter int ADDR_W         = 10,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0]  xfer_count,
  mem_bus_dma_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_GAP, WR, WR_GAP, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmo_hit;
  logic              unused_bits;

  assign unused_bits = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef MEM_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_d   = '0;
    if (state_q == RD || state_q == WR)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    wstrb_d = wstrb_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high during the done cycle, so start is ignored
        if (start && !busy_q) begin
          src_d  = {src_addr[ADDR_W-1:2], 2'b00};
          dst_d  = {dst_addr[ADDR_W-1:2], 2'b00};
          len_d  = len;
          cnt_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d = RD;
            valid_d = 1'b1;
            wstrb_d = 4'h0;
            addr_d  = {src_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          buf_d   = bus.mem_rdata;
          valid_d = 1'b0;
          state_d = RD_GAP;
        end else if (tmo_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RD_GAP: begin
        valid_d = 1'b1;
        wstrb_d = 4'hF;
        addr_d  = dst_q;
        state_d = WR;
      end
      WR: begin
        if (bus.mem_ready) begin
          valid_d = 1'b0;
          src_d   = src_q + ADDR_W'(4);
          dst_d   = dst_q + ADDR_W'(4);
          cnt_d   = cnt_q + 1'b1;
          state_d = WR_GAP;
        end else if (tmo_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WR_GAP: begin
        if (cnt_q == len_q) begin
          state_d = DONE;
        end else begin
          valid_d = 1'b1;
          wstrb_d = 4'h0;
          addr_d  = src_q;
          state_d = RD;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      wstrb_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      wstrb_q <= wstrb_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = buf_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign xfer_count    = cnt_q;

endmodule

// File: doc/mem_bus_dma.md
Name: mem_bus_dma

Overview:
- Word-copy initiator on the team's native memory bus (mem_valid / mem_ready / mem_wstrb / mem_addr / mem_wdata / mem_rdata).
- Drives the bus as the master; the team's memory responders sit on the other side.
- Copies len 32-bit words from src_addr to dst_addr as alternating read and write transactions.
- Used for boot-time preloading of instruction memory and block moves without CPU involvement.

Parameters:
- ADDR_W, 10: byte-address width of mem_addr; addresses wrap modulo 2^ADDR_W.
- LEN_W, 8: width of the len and xfer_count words.
- TIMEOUT_CYCLES, 16: cycles to wait for mem_ready before abort; used only with MEM_DMA_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address; bits [1:0] ignored
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of words to copy
- busy  out  1  high from accepted start until done pulse inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  set on timeout abort; cleared on next accepted start
- xfer_count  out  LEN_W  words fully written in current/last transfer
- mem_valid  out  1  bus request
- mem_ready  in  1  responder completion
- mem_wstrb  out  4  4'h0 for reads, 4'hF for writes
- mem_addr  out  ADDR_W  word-aligned byte address, [1:0] always 2'b00
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid in the cycle mem_ready is high

Behaviour:
- Reset (async, resetn=0): all outputs 0, state IDLE, internal address/count/buffer registers cleared. Any in-flight transaction is abandoned immediately, with mem_valid low in the same instant.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE:
  - start=1 latches src/dst (with [1:0] forced to 0) and len, clears xfer_count and err, and sets busy.
  - Next state is RD, or DONE if len==0.
- RD:
  - Outputs: mem_valid=1, mem_wstrb=0, mem_addr=current src.
  - Held stable until mem_ready is sampled high.
  - On that edge: capture mem_rdata into the word buffer, drive mem_valid=0, go to RD_GAP.
- RD_GAP: one cycle with mem_valid=0, then WR. The guaranteed idle cycle between transactions keeps the responder's ready/valid overlap unambiguous.
- WR:
  - Outputs: mem_valid=1, mem_wstrb=4'hF, mem_addr=current dst, mem_wdata=buffer.
  - On mem_ready: drive mem_valid=0, src+=4, dst+=4 (wrapping modulo 2^ADDR_W), xfer_count+=1, go to WR_GAP.
- WR_GAP: one cycle with mem_valid=0. Go to DONE if xfer_count==len, else RD.
- DONE: done=1 for exactly one cycle, busy still 1. Next cycle busy=0 and state IDLE.
- mem_valid is never high outside RD/WR. All bus outputs are registered.
- start while busy is ignored; no queueing.
- len==0: no bus traffic. The transfer passes through DONE, so done pulses in the second cycle after the start edge.
- Overlapping src/dst regions: copy is strictly ascending word by word; no overlap protection.
- Minimum cost per word with a 1-cycle responder: 6 cycles (RD, RD wait, gap, WR, WR wait, gap).

Optional Feature:
- Macro: MEM_DMA_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in RD or WR, reset on entry to each.
  - If TIMEOUT_CYCLES cycles elapse with mem_ready never sampled high: drive mem_valid=0, set err=1, go to DONE.
  - xfer_count holds the number of words completed before the abort.
- Without the macro: no counter; RD/WR wait indefinitely; err is tied to 0.

Test Plan:
- Bench uses the team's 1-cycle-latency memory responder model throughout; scenarios 5 and 6 replace it with the models stated on those lines.
- Scenario 1: preload bytes 0x000..0x00C with 0x11111111, 0x22222222, 0x33333333, 0x44444444; start src=0x000 dst=0x100 len=4 -> words 0x100..0x10C hold the same values. Bus shows 4 reads (wstrb=0) alternating with 4 writes (wstrb=F), one done pulse, xfer_count=4, busy low the cycle after done.
- Scenario 2: start len=0 -> done pulses in the second cycle after start, mem_valid never asserted, xfer_count=0.
- Scenario 3: ADDR_W=10, src=0x3FC dst=0x200 len=2 -> reads at 0x3FC then 0x000 (wrap); writes at 0x200 and 0x204.
- Scenario 4:
  - Assert start again mid-transfer -> ignored; len and addresses are unchanged.
  - Then drop resetn during a WR -> mem_valid, busy, done and xfer_count are 0 immediately.
  - After release, a fresh start with len=1 completes normally.
- Scenario 5: responder inserts a 3-cycle wait before mem_ready -> mem_addr, mem_wdata and mem_wstrb stay stable throughout; data is copied correctly.
- Scenario 6: MEM_DMA_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, responder never ready -> mem_valid drops after 16 cycles in RD, err=1, done pulses once, xfer_count=0. With the macro undefined the same stimulus gives busy held high and err=0.
